// File: rtl/hash_state_acc.sv
// Chaining-value accumulator for the SHA-256 datapath: holds WORDS state words, adds each
// compression output word-wise, and flags the digest after nblocks beats. Optional feature: HASH_ACC_MIDSTATE_EN.
module hash_state_acc #(
   parameter int                         WORDS = 8,
   parameter int                         WIDTH = 32,
   parameter int                         CNT_W = 8,
   parameter logic [WORDS*WIDTH-1:0]     IV    = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667}
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_W-1:0]         nblocks,
`ifdef HASH_ACC_MIDSTATE_EN
   input  logic                     midstate_load,
   input  logic [WORDS*WIDTH-1:0]   midstate_in,
`endif
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORDS*WIDTH-1:0]   in_data,
   output logic [WORDS*WIDTH-1:0]   h_out,
   output logic [CNT_W-1:0]         block_idx,
   output logic                     busy,
   output logic                     digest_valid
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [WORDS*WIDTH-1:0]   h_q, h_d;
   logic [CNT_W-1:0]         idx_q, idx_d;
   logic [CNT_W-1:0]         nblk_q, nblk_d;
   logic                     in_ready_q, in_ready_d;
   logic                     busy_q, busy_d;
   logic                     digest_valid_q, digest_valid_d;
   logic [WORDS*WIDTH-1:0]   load_value;
   logic                     accept;

`ifdef HASH_ACC_MIDSTATE_EN
   assign load_value = midstate_load ? midstate_in : IV;
`else
   assign load_value = IV;
`endif

   // in_ready_q is only ever high in ACCUM, so it doubles as the state qualifier for a beat
   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d        = state_q;
      h_d            = h_q;
      idx_d          = idx_q;
      nblk_d         = nblk_q;
      if (start) begin
         h_d     = load_value;
         idx_d   = '0;
         nblk_d  = nblocks;
         state_d = (nblocks != '0) ? ACCUM : DONE;
      end else if (state_q == ACCUM && accept) begin
         // Word-sliced addition keeps carries inside each word
         for (int i = 0; i < WORDS; i++) begin
            h_d[i*WIDTH +: WIDTH] = h_q[i*WIDTH +: WIDTH] + in_data[i*WIDTH +: WIDTH];
         end
         idx_d = idx_q + CNT_W'(1);
         if (idx_q == nblk_q - CNT_W'(1)) begin
            state_d = DONE;
         end
      end
      in_ready_d     = (state_d == ACCUM);
      busy_d         = (state_d == ACCUM);
      digest_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         h_q            <= IV;
         idx_q          <= '0;
         nblk_q         <= '0;
         in_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         digest_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         h_q            <= h_d;
         idx_q          <= idx_d;
         nblk_q         <= nblk_d;
         in_ready_q     <= in_ready_d;
         busy_q         <= busy_d;
         digest_valid_q <= digest_valid_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign h_out        = h_q;
   assign block_idx    = idx_q;
   assign busy         = busy_q;
   assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_hash_state_acc.sv
// Self-checking bench for hash_state_acc: directed vector table, long-message and
// midstate sequences, then randomized traffic against a word-array reference model.
module tb_hash_state_acc;

   localparam int WORDS = 8;
   localparam int WIDTH = 32;
   localparam int CNT_W = 8;
   localparam int HW    = WORDS*WIDTH;
   localparam logic [HW-1:0] IV_FLAT = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   localparam int M_IDLE  = 0;
   localparam int M_ACCUM = 1;
   localparam int M_DONE  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  nblocks = '0;
   logic              in_valid = 1'b0;
   logic [HW-1:0]     in_data = '0;
   logic              midstate_load = 1'b0;
   logic [HW-1:0]     midstate_in = '0;
   logic              in_ready;
   logic [HW-1:0]     h_out;
   logic [CNT_W-1:0]  block_idx;
   logic              busy;
   logic              digest_valid;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: plain word array plus counters
   int unsigned m_h [WORDS];
   int          m_idx;
   int          m_nblk;
   int          m_st;

   hash_state_acc dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .nblocks      (nblocks),
`ifdef HASH_ACC_MIDSTATE_EN
      .midstate_load(midstate_load),
      .midstate_in  (midstate_in),
`endif
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .h_out        (h_out),
      .block_idx    (block_idx),
      .busy         (busy),
      .digest_valid (digest_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              rst;
      logic              start;
      logic [CNT_W-1:0]  nb;
      logic              valid;
      logic [31:0]       d0, d1, d3;
      logic [31:0]       e0, e1, e3;
      logic [CNT_W-1:0]  eidx;
      logic              erdy, ebusy, edv;
   } vec_t;

   function automatic logic [HW-1:0] setWords(input logic [HW-1:0] base,
                                               input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w3);
      logic [HW-1:0] v;
      v = base;
      v[31:0]   = w0;
      v[63:32]  = w1;
      v[127:96] = w3;
      return v;
   endfunction

   function automatic logic [HW-1:0] modelFlat();
      logic [HW-1:0] v;
      for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = m_h[i];
      return v;
   endfunction

   task automatic modelStep(input logic r, input logic s, input logic [CNT_W-1:0] nb,
                            input logic v, input logic [HW-1:0] d,
                            input logic ml, input logic [HW-1:0] mi);
      logic [HW-1:0] src;
      if (r) begin
         for (int i = 0; i < WORDS; i++) m_h[i] = IV_FLAT[i*32 +: 32];
         m_idx = 0; m_nblk = 0; m_st = M_IDLE;
      end else if (s) begin
         src = IV_FLAT;
`ifdef HASH_ACC_MIDSTATE_EN
         if (ml) src = mi;
`else
         if (ml && mi != mi) src = mi;
`endif
         for (int i = 0; i < WORDS; i++) m_h[i] = src[i*32 +: 32];
         m_idx  = 0;
         m_nblk = int'(nb);
         m_st   = (nb == 0) ? M_DONE : M_ACCUM;
      end else if (m_st == M_ACCUM && v) begin
         for (int i = 0; i < WORDS; i++) m_h[i] = m_h[i] + d[i*32 +: 32];
         m_idx++;
         if (m_idx == m_nblk) m_st = M_DONE;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic [CNT_W-1:0] nb,
                                input logic v, input logic [HW-1:0] d,
                                input logic ml, input logic [HW-1:0] mi);
      rst = r; start = s; nblocks = nb; in_valid = v; in_data = d;
      midstate_load = ml; midstate_in = mi;
      modelStep(r, s, nb, v, d, ml, mi);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [HW-1:0] eh,
                              input logic [CNT_W-1:0] eidx, input logic erdy,
                              input logic ebusy, input logic edv);
      vectors++;
      if (h_out !== eh || block_idx !== eidx || in_ready !== erdy ||
          busy !== ebusy || digest_valid !== edv) begin
         miscompares++;
         $display("[TB] FAIL %s: got h=%h idx=%0d rdy=%b busy=%b dv=%b, want h=%h idx=%0d rdy=%b busy=%b dv=%b",
                  name, h_out, block_idx, in_ready, busy, digest_valid, eh, eidx, erdy, ebusy, edv);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, modelFlat(), CNT_W'(m_idx), m_st == M_ACCUM, m_st == M_ACCUM, m_st == M_DONE);
   endtask

   vec_t vecs [17];

   initial begin
      logic [HW-1:0] d;
      logic [HW-1:0] mi;
      int beats;

      // rst, start, nb, valid, d0, d1, d3, e0, e1, e3, eidx, rdy, busy, dv
      vecs[0]  = '{1'b1, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53b, 8'd1, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53c, 8'd2, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53c, 8'd2, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 8'd1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h95f61999, 32'hffffffff, 32'h0, 32'h00000000, 32'hbb67ae84, 32'ha54ff53a, 8'd1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 8'd3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h5, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53f, 8'd1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'd3, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53b, 8'd1, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 8'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h7, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b1, 8'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 32'h0, 32'h9, 32'h6a09e667, 32'hbb67ae85, 32'ha54ff53a, 8'd0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         d = setWords('0, vecs[i].d0, vecs[i].d1, vecs[i].d3);
         applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].nb, vecs[i].valid, d, 1'b0, '0);
         checkOutput($sformatf("vec%0d", i), setWords(IV_FLAT, vecs[i].e0, vecs[i].e1, vecs[i].e3),
                     vecs[i].eidx, vecs[i].erdy, vecs[i].ebusy, vecs[i].edv);
      end

      // Longest legal message with occasional bubbles; index must reach 255 without wrapping
      $display("[TB] long message, nblocks=255");
      applyStimulus(1'b0, 1'b1, 8'd255, 1'b0, '0, 1'b0, '0);
      checkModel("long_start");
      beats = 0;
      for (int c = 0; c < 400 && beats < 255; c++) begin
         if (c % 10 == 9) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, setWords('0, 32'h1, 32'h0, 32'h0), 1'b0, '0);
         end else begin
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, setWords('0, 32'h1, 32'h0, 32'h0), 1'b0, '0);
            beats++;
         end
         if (c % 50 == 0) checkModel("long_beat");
      end
      checkOutput("long_final", setWords(IV_FLAT, 32'h6a09e766, 32'hbb67ae85, 32'ha54ff53a),
                  8'd255, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, setWords('0, 32'h1, 32'h0, 32'h0), 1'b0, '0);
      checkOutput("long_hold", setWords(IV_FLAT, 32'h6a09e766, 32'hbb67ae85, 32'ha54ff53a),
                  8'd255, 1'b0, 1'b0, 1'b1);

`ifdef HASH_ACC_MIDSTATE_EN
      $display("[TB] midstate resume");
      mi = setWords(IV_FLAT, 32'h6a09e667, 32'hbb67ae85, 32'h12345678);
      applyStimulus(1'b0, 1'b1, 8'd1, 1'b0, '0, 1'b1, mi);
      checkOutput("mid_load", mi, 8'd0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, setWords('0, 32'h0, 32'h0, 32'h2), 1'b0, '0);
      checkOutput("mid_beat", setWords(IV_FLAT, 32'h6a09e667, 32'hbb67ae85, 32'h1234567a),
                  8'd1, 1'b0, 1'b0, 1'b1);
`endif

      // Randomized traffic against the reference model
      $display("[TB] random traffic");
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b0, '0);
      checkModel("rnd_reset");
      for (int c = 0; c < 600; c++) begin
         for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = $urandom;
         for (int w = 0; w < WORDS; w++) mi[w*32 +: 32] = $urandom;
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                       CNT_W'($urandom_range(0, 5)), $urandom_range(0, 3) != 0, d,
                       $urandom_range(0, 1) == 1, mi);
         checkModel($sformatf("rnd%0d", c));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hash_state_acc.md
# hash_state_acc

Parametrised chaining-value accumulator for the SHA-256 datapath. It holds all WORDS hash-state words and loads them with the initial value when a message starts. After each compression round it adds the compression output into the held state, modulo 2^WIDTH. A block counter with a valid/ready handshake marks the final block and flags the digest. It sits between the message scheduler/compression core (upstream) and the nonce/compare logic (downstream), and replaces the single-word, fixed-two-block accumulators.

## Interface
Parameters:
- WORDS, 8, number of state words
- WIDTH, 32, bits per word
- CNT_W, 8, width of block count/index
- IV, SHA-256 IV, flat WORDS*WIDTH vector; word i at bits [i*WIDTH +: WIDTH]; default word0..7 = 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin new message: load IV, clear index
- nblocks  in  CNT_W  blocks in message, sampled on start
- in_valid  in  1  compression output valid
- in_ready  out  1  accumulator accepts a beat
- in_data  in  WORDS*WIDTH  compression working variables, same word packing as IV
- h_out  out  WORDS*WIDTH  current chaining value / final digest
- block_idx  out  CNT_W  blocks accumulated so far
- busy  out  1  message in progress
- digest_valid  out  1  h_out holds final digest

## Operation
- States: IDLE, ACCUM, DONE.
- Reset values:
  - state = IDLE
  - h_out = IV
  - block_idx = 0
  - in_ready = 0
  - busy = 0
  - digest_valid = 0
- start, in any state:
  - h_out <= IV, block_idx <= 0.
  - The sampled nblocks is latched into an internal register.
  - If nblocks ≠ 0, go to ACCUM. If nblocks = 0, go to DONE with h_out = IV.
- ACCUM:
  - in_ready = 1 and busy = 1.
  - On in_valid && in_ready, each word updates h[i] <= h[i] + d[i] mod 2^WIDTH, with carries never crossing word boundaries. block_idx increments.
  - If the accepted beat has block_idx == latched nblocks − 1, go to DONE.
- DONE:
  - digest_valid = 1, busy = 0, in_ready = 0.
  - h_out is held. The block stays in DONE until the next start.
- IDLE: in_ready = 0. in_valid is ignored.
- start and in_valid in the same cycle: start wins and the beat is dropped (not added, not counted).
- in_valid outside ACCUM: ignored, with no state change.
- rst has priority over start. rst mid-message discards the partial state and returns to reset values next cycle.
- block_idx never wraps: at most nblocks ≤ 2^CNT_W − 1 beats are accepted per message.

## Timing
- Latency is 1 cycle from an accepted beat to the updated h_out and block_idx.
- digest_valid rises in the cycle after the final beat is accepted. It is level, held until start or rst.
- start takes effect on the next edge: h_out = IV and in_ready = 1 (if nblocks ≠ 0) in the following cycle.
- Full throughput: one beat per cycle while in ACCUM.
- in_ready is a registered state decode and has no combinational path from in_valid.

## Configuration
- HASH_ACC_MIDSTATE_EN defined:
  - Adds ports midstate_load (in, 1) and midstate_in (in, WORDS*WIDTH).
  - start with midstate_load = 1 loads midstate_in instead of IV. The remaining behaviour is identical.
  - This is used to resume a bitcoin header hash from a precomputed first-block midstate.
- HASH_ACC_MIDSTATE_EN undefined: these ports are absent and start always loads IV.

## Test plan
- Reset then idle:
  - After rst, h_out word3 = a54ff53a, word0 = 6a09e667.
  - in_ready = 0, digest_valid = 0, and in_valid pulses leave h_out unchanged.
- Two-block message:
  - Send start with nblocks = 2.
  - Beat 1 with word3 = 00000001, others 0 → word3 = a54ff53b.
  - Beat 2 with word3 = 00000001 → word3 = a54ff53c, block_idx = 2.
  - digest_valid = 1 exactly one cycle after beat 2 is accepted.
- Per-word wrap:
  - Send start with nblocks = 1 and one beat with word0 = 95f61999, word1 = ffffffff.
  - Expect word0 = 00000000 and word1 = bb67ae84, with no carry into word1.
- Start collision and restart:
  - In ACCUM, assert start with in_valid in the same cycle → beat dropped, h_out = IV, block_idx = 0.
  - In DONE, assert start → digest_valid falls the next cycle.
- Zero blocks and mid-message reset:
  - start with nblocks = 0 → DONE with h_out = IV and digest_valid = 1.
  - rst asserted after one of three beats → all outputs return to reset values.
- Midstate (HASH_ACC_MIDSTATE_EN):
  - start with midstate_load = 1 and midstate_in word3 = 12345678, then one beat word3 = 00000002 → word3 = 1234567a.
